// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit_pkg
// Purpose  : Access-size encodings and FSM state type shared by the LSU files.
// Revision : 1.0 - initial release
// ============================================================================
package load_store_unit_pkg;

    localparam logic [1:0] SIZE_BYTE   = 2'b00;
    localparam logic [1:0] SIZE_HALF   = 2'b01;
    localparam logic [1:0] SIZE_WORD   = 2'b10;
    localparam logic [1:0] SIZE_DOUBLE = 2'b11;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        STORE     = 3'd1,
        LOAD_ADDR = 3'd2,
        LOAD_WAIT = 3'd3,
        RESP      = 3'd4
    } lsuState_t;

endpackage
`default_nettype wire

// File: rtl/lsu_align_check.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align_check
// Purpose  : Combinational misalignment detect from the low address bits.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_align_check
    import load_store_unit_pkg::*;
(
    input  logic [2:0] addressLow,
    input  logic [1:0] size,
    output logic       misaligned
);

    always_comb begin
        misaligned = 1'b0;
        case (size)
            SIZE_BYTE:   misaligned = 1'b0;
            SIZE_HALF:   misaligned = addressLow[0];
            SIZE_WORD:   misaligned = |addressLow[1:0];
            SIZE_DOUBLE: misaligned = |addressLow[2:0];
            default:     misaligned = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Single-outstanding load/store sequencer for the on-chip data memory.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic                  reqWrite,
    input  logic [ADDR_WIDTH-1:0] reqAddress,
    input  logic [DATA_WIDTH-1:0] reqWriteData,
    input  logic [1:0]            reqSize,
    input  logic                  reqSignExtended,
    output logic                  respValid,
    input  logic                  respReady,
    output logic [DATA_WIDTH-1:0] respReadData,
    output logic                  respMisaligned,
    output logic [ADDR_WIDTH-1:0] memAddress,
    output logic [DATA_WIDTH-1:0] memWriteData,
    output logic                  memSignExtended,
    output logic [1:0]            memWriteSize,
    output logic                  memWriteEnable,
    input  logic [DATA_WIDTH-1:0] memReadData,
    output logic [15:0]           loadCount,
    output logic [15:0]           storeCount
);

    lsuState_t             r_state;
    lsuState_t             w_nextState;
    logic                  w_accept;
    logic                  w_misaligned;
    logic                  w_memActive;
    logic [DATA_WIDTH-1:0] w_loadData;

    logic [ADDR_WIDTH-1:0] r_address;
    logic [DATA_WIDTH-1:0] r_writeData;
    logic [1:0]            r_size;
    logic                  r_signExtended;
    logic [DATA_WIDTH-1:0] r_respReadData;
    logic                  r_respMisaligned;
    logic [15:0]           r_loadCount;
    logic [15:0]           r_storeCount;

    lsu_align_check u_alignCheck (
        .addressLow (reqAddress[2:0]),
        .size       (reqSize),
        .misaligned (w_misaligned)
    );

    assign w_accept = reqValid && (r_state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (reqValid) begin
                    if (w_misaligned)  w_nextState = RESP;
                    else if (reqWrite) w_nextState = STORE;
                    else               w_nextState = LOAD_ADDR;
                end
            end
            STORE:     w_nextState = RESP;
            LOAD_ADDR: w_nextState = LOAD_WAIT;
            LOAD_WAIT: w_nextState = RESP;
            RESP:      if (respReady) w_nextState = IDLE;
            default:   w_nextState = IDLE;
        endcase
    end

    // Memory-side outputs are zeroed whenever no access is in flight.
    always_comb begin
        reqReady        = (r_state == IDLE);
        respValid       = (r_state == RESP);
        memWriteEnable  = (r_state == STORE);
        w_memActive     = (r_state == STORE) || (r_state == LOAD_ADDR) || (r_state == LOAD_WAIT);
        memAddress      = w_memActive ? r_address      : '0;
        memWriteData    = w_memActive ? r_writeData    : '0;
        memWriteSize    = w_memActive ? r_size         : 2'b00;
        memSignExtended = w_memActive ? r_signExtended : 1'b0;
    end

    // Memory returns its bytes at the low end; size them and extend here.
    always_comb begin
        w_loadData = memReadData;
        case (r_size)
            SIZE_BYTE:   w_loadData = {{(DATA_WIDTH-8){r_signExtended & memReadData[7]}}, memReadData[7:0]};
            SIZE_HALF:   w_loadData = {{(DATA_WIDTH-16){r_signExtended & memReadData[15]}}, memReadData[15:0]};
            SIZE_WORD:   w_loadData = {{(DATA_WIDTH-32){r_signExtended & memReadData[31]}}, memReadData[31:0]};
            SIZE_DOUBLE: w_loadData = memReadData;
            default:     w_loadData = memReadData;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_address        <= '0;
            r_writeData      <= '0;
            r_size           <= 2'b00;
            r_signExtended   <= 1'b0;
            r_respReadData   <= '0;
            r_respMisaligned <= 1'b0;
            r_loadCount      <= 16'd0;
            r_storeCount     <= 16'd0;
        end else begin
            if (w_accept) begin
                r_address        <= reqAddress;
                r_writeData      <= reqWriteData;
                r_size           <= reqSize;
                r_signExtended   <= reqSignExtended;
                r_respReadData   <= '0;
                r_respMisaligned <= w_misaligned;
                if (!w_misaligned) begin
                    if (reqWrite && (r_storeCount != 16'hFFFF)) r_storeCount <= r_storeCount + 16'd1;
                    if (!reqWrite && (r_loadCount != 16'hFFFF)) r_loadCount <= r_loadCount + 16'd1;
                end
            end
            if (r_state == LOAD_WAIT) begin
                r_respReadData <= w_loadData;
            end
        end
    end

    assign respReadData   = r_respReadData;
    assign respMisaligned = r_respMisaligned;
    assign loadCount      = r_loadCount;
    assign storeCount     = r_storeCount;

endmodule
`default_nettype wire
